// File: rtl/int_res_mem_arbiter.sv
// Round-robin arbiter and access sequencer for the banked intermediate-result memory.
// One requester is served at a time. A double-width access becomes two consecutive
// single-word bank accesses (upper half at addr, lower half at addr+1).
module int_res_mem_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 14336,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 15,
    parameter int BA_W       = 14
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ-1:0]                  req_we_i,
    input  logic [NUM_REQ-1:0]                  req_width_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]      req_addr_i,
    input  logic [NUM_REQ-1:0][2*DATA_W-1:0]    req_wdata_i,
    output logic [NUM_REQ-1:0]                  gnt_o,
    output logic [NUM_REQ-1:0]                  rvalid_o,
    output logic [NUM_REQ-1:0]                  done_o,
    output logic [2*DATA_W-1:0]                 rdata_o,
    output logic                                addr_err_o,
    output logic [NUM_BANKS-1:0]                bank_en_o,
    output logic                                bank_we_o,
    output logic [BA_W-1:0]                     bank_addr_o,
    output logic [DATA_W-1:0]                   bank_wdata_o,
    input  logic [NUM_BANKS-1:0][DATA_W-1:0]    bank_rdata_i
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_BANKS * BANK_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACC1   = 3'd1;
    localparam logic [2:0] S_ACC2   = 3'd2;
    localparam logic [2:0] S_RDWAIT = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    // Bank index of a flat address (the address must already be in range).
    function automatic logic [BANK_W-1:0] dec_bank(input logic [ADDR_W:0] a);
        logic [31:0] a32;
        logic [BANK_W-1:0] b_sel;
        a32   = 32'(a);
        b_sel = '0;
        for (int b = 1; b < NUM_BANKS; b++)
            if (a32 >= 32'(b * BANK_DEPTH)) b_sel = BANK_W'(b);
        return b_sel;
    endfunction

    // In-bank word offset for a flat address in the given bank.
    function automatic logic [BA_W-1:0] dec_off(input logic [ADDR_W:0] a, input logic [BANK_W-1:0] b);
        logic [31:0] off;
        off = 32'(a) - 32'(b) * 32'(BANK_DEPTH);
        return off[BA_W-1:0];
    endfunction

    logic [2:0]           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, wsel_q, win;
    logic                 we_q, dw_q, err_q, found, grant;
    logic [ADDR_W-1:0]    addr_q;
    logic [2*DATA_W-1:0]  wdata_q, rdata_q;
    logic [DATA_W-1:0]    hi_q, lo_rd;
    logic [BANK_W-1:0]    last_bank_q, bank_sel;
    logic [ADDR_W:0]      acc_addr;
    logic                 oor, acc_active;

    // Round-robin search starting one past the last winner.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        // RESP doubles as an idle cycle so back-to-back grants lose no cycle.
        grant = (state_q == S_IDLE || state_q == S_RESP) && found && !rst_i;
        gnt_o = '0;
        if (grant) gnt_o[win] = 1'b1;
    end

    // Address decode and bank-side drive for the current access cycle.
    always_comb begin
        acc_addr   = (state_q == S_ACC2) ? ({1'b0, addr_q} + 1'b1) : {1'b0, addr_q};
        oor        = ({1'b0, addr_q} >= LIMIT) || (dw_q && (({1'b0, addr_q} + 1'b1) >= LIMIT));
        acc_active = ((state_q == S_ACC1) && !oor) || (state_q == S_ACC2);
        bank_sel   = dec_bank(acc_addr);
        bank_en_o    = '0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_we_o    = acc_active && we_q;
        if (acc_active) begin
            bank_en_o[bank_sel] = 1'b1;
            bank_addr_o         = dec_off(acc_addr, bank_sel);
            if (we_q)
                bank_wdata_o = ((state_q == S_ACC1) && dw_q) ? wdata_q[2*DATA_W-1:DATA_W]
                                                             : wdata_q[DATA_W-1:0];
        end
        lo_rd = bank_rdata_i[last_bank_q];
    end

    // Sequencer next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_RESP: state_d = grant ? S_ACC1 : S_IDLE;
            S_ACC1: begin
                if (oor)        state_d = S_RESP;
                else if (dw_q)  state_d = S_ACC2;
                else if (!we_q) state_d = S_RDWAIT;
                else            state_d = S_RESP;
            end
            S_ACC2:   state_d = we_q ? S_RESP : S_RDWAIT;
            S_RDWAIT: state_d = S_RESP;
            default:  state_d = S_IDLE;
        endcase
    end

    // Response pulses are tied to the RESP state and the captured requester.
    always_comb begin
        rvalid_o = '0;
        done_o   = '0;
        if (state_q == S_RESP) begin
            rvalid_o[wsel_q] = !we_q;
            done_o[wsel_q]   = we_q;
        end
        addr_err_o = (state_q == S_RESP) && err_q;
        rdata_o    = rdata_q;
    end

    // State, request capture and read-data assembly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            wsel_q      <= '0;
            we_q        <= 1'b0;
            dw_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            hi_q        <= '0;
            last_bank_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                ptr_q   <= win;
                wsel_q  <= win;
                we_q    <= req_we_i[win];
                dw_q    <= req_width_i[win];
                addr_q  <= req_addr_i[win];
                wdata_q <= req_wdata_i[win];
                err_q   <= 1'b0;
            end
            if (state_q == S_ACC1) begin
                err_q <= oor;
                if (oor && !we_q) rdata_q <= '0;
            end
            if (acc_active) last_bank_q <= bank_sel;
            // Upper half comes back while the second access is on the bus.
            if (state_q == S_ACC2) hi_q <= lo_rd;
            if (state_q == S_RDWAIT)
                rdata_q <= dw_q ? {hi_q, lo_rd} : {{DATA_W{lo_rd[DATA_W-1]}}, lo_rd};
        end
    end

endmodule
